exception_unit: RTL and testbench

EXCEPTION_UNIT -- requirements
Module: exception_unit

---
 rtl/exception_unit.sv | 194 +++++++++++++++++++
 tb/tb_exception_unit.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_unit.sv
// Exception sequencer: picks the oldest faulting pipeline stage (or a pending
// external interrupt), pulses one cause to coprocessor 0, flushes, then waits for EXL.
module exception_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_addrl,
    input  logic        id_ri,
    input  logic        id_sys,
    input  logic        id_tr,
    input  logic        ex_ovf,
    input  logic        mem_addrs,
    input  logic        mem_addrl,
    input  logic [31:0] if_pc,
    input  logic [31:0] id_pc,
    input  logic [31:0] ex_pc,
    input  logic [31:0] mem_pc,
    input  logic [31:0] if_badaddr,
    input  logic [31:0] mem_badaddr,
    input  logic        irq,
    input  logic        exc_level,
    output logic        int_ext,
    output logic        int_tr,
    output logic        int_ovf,
    output logic        int_ri,
    output logic        int_sys,
    output logic        int_addrs,
    output logic        int_addrl,
    output logic [31:0] epc_out,
    output logic [31:0] badvaddr_out,
    output logic        flush,
    output logic        stall,
    output logic [15:0] exc_count
);

    // state  | meaning
    // IDLE   | watching sources; accepts one when exc_level is low
    // REPORT | one-cycle cause pulse, epc/badvaddr presented, pipeline stalled
    // FLUSH  | pipeline contents killed, still stalled
    // BUSY   | handler running; all sources ignored until exc_level drops
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPORT = 2'd1,
        FLUSH  = 2'd2,
        BUSY   = 2'd3
    } state_t;

    localparam logic [6:0] C_ADDRL = 7'b000_0001;
    localparam logic [6:0] C_ADDRS = 7'b000_0010;
    localparam logic [6:0] C_SYS   = 7'b000_0100;
    localparam logic [6:0] C_RI    = 7'b000_1000;
    localparam logic [6:0] C_OVF   = 7'b001_0000;
    localparam logic [6:0] C_TR    = 7'b010_0000;
    localparam logic [6:0] C_EXT   = 7'b100_0000;

    state_t      state;
    logic [6:0]  cause_q;
    logic [31:0] epc_q;
    logic [31:0] bad_q;
    logic [15:0] count_q;
    logic        flush_q;
    logic        stall_q;

    logic        irq_q;
    logic        irq_armed;
    logic        irq_pending;
    logic        irq_rise;

    logic [6:0]  sel_cause;
    logic [31:0] sel_epc;
    logic [31:0] sel_bad;
    logic        accept;
    logic        take_ext;

    // Oldest stage wins; the external interrupt is reported at the EX boundary.
    always_comb begin
        sel_cause = '0;
        sel_epc   = '0;
        sel_bad   = '0;
        if (mem_addrl) begin
            sel_cause = C_ADDRL;
            sel_epc   = mem_pc;
            sel_bad   = mem_badaddr;
        end else if (mem_addrs) begin
            sel_cause = C_ADDRS;
            sel_epc   = mem_pc;
            sel_bad   = mem_badaddr;
        end else if (ex_ovf) begin
            sel_cause = C_OVF;
            sel_epc   = ex_pc;
        end else if (id_ri) begin
            sel_cause = C_RI;
            sel_epc   = id_pc;
        end else if (id_sys) begin
            sel_cause = C_SYS;
            sel_epc   = id_pc;
        end else if (id_tr) begin
            sel_cause = C_TR;
            sel_epc   = id_pc;
        end else if (if_addrl) begin
            sel_cause = C_ADDRL;
            sel_epc   = if_pc;
            sel_bad   = if_badaddr;
        end else if (irq_pending) begin
            sel_cause = C_EXT;
            sel_epc   = ex_pc;
        end
    end

    assign accept   = (state == IDLE) && !exc_level && (sel_cause != '0);
    assign take_ext = accept && (sel_cause == C_EXT);

    // irq_armed masks the first sample after reset so a line already high is not an edge.
    assign irq_rise = irq_armed && irq && !irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q       <= 1'b0;
            irq_armed   <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            irq_q       <= irq;
            irq_armed   <= 1'b1;
            irq_pending <= (irq_pending && !take_ext) || irq_rise;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            bad_q   <= '0;
            count_q <= '0;
            flush_q <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cause_q <= '0;
                    flush_q <= 1'b0;
                    stall_q <= 1'b0;
                    if (accept) begin
                        state   <= REPORT;
                        cause_q <= sel_cause;
                        epc_q   <= sel_epc;
                        bad_q   <= sel_bad;
                        stall_q <= 1'b1;
                        count_q <= count_q + 16'd1;
                    end
                end
                REPORT: begin
                    state   <= FLUSH;
                    cause_q <= '0;
                    flush_q <= 1'b1;
                    stall_q <= 1'b1;
                end
                FLUSH: begin
                    state   <= BUSY;
                    cause_q <= '0;
                    flush_q <= 1'b0;
                    stall_q <= 1'b0;
                end
                BUSY: begin
                    cause_q <= '0;
                    flush_q <= 1'b0;
                    stall_q <= 1'b0;
                    if (!exc_level) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cause_q <= '0;
                    flush_q <= 1'b0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign int_addrl    = cause_q[0];
    assign int_addrs    = cause_q[1];
    assign int_sys      = cause_q[2];
    assign int_ri       = cause_q[3];
    assign int_ovf      = cause_q[4];
    assign int_tr       = cause_q[5];
    assign int_ext      = cause_q[6];
    assign epc_out      = epc_q;
    assign badvaddr_out = bad_q;
    assign flush        = flush_q;
    assign stall        = stall_q;
    assign exc_count    = count_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: priority, pulse/flush timing, irq pending,
// EXL masking, async reset and counter wrap.
module tb_exception_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_addrl, id_ri, id_sys, id_tr, ex_ovf, mem_addrs, mem_addrl;
    logic [31:0] if_pc, id_pc, ex_pc, mem_pc, if_badaddr, mem_badaddr;
    logic        irq, exc_level;
    logic        int_ext, int_tr, int_ovf, int_ri, int_sys, int_addrs, int_addrl;
    logic [31:0] epc_out, badvaddr_out;
    logic        flush, stall;
    logic [15:0] exc_count;

    logic [6:0]  ints;
    logic [15:0] exp_count;
    int          checks   = 0;
    int          failures = 0;

    // Cause bit order: {ext, tr, ovf, ri, sys, addrs, addrl}
    localparam logic [6:0] E_NONE  = 7'h00;
    localparam logic [6:0] E_ADDRL = 7'h01;
    localparam logic [6:0] E_ADDRS = 7'h02;
    localparam logic [6:0] E_SYS   = 7'h04;
    localparam logic [6:0] E_RI    = 7'h08;
    localparam logic [6:0] E_OVF   = 7'h10;
    localparam logic [6:0] E_TR    = 7'h20;
    localparam logic [6:0] E_EXT   = 7'h40;

    // Source flag masks for set_flags
    localparam logic [6:0] F_MEML = 7'h01;
    localparam logic [6:0] F_MEMS = 7'h02;
    localparam logic [6:0] F_OVF  = 7'h04;
    localparam logic [6:0] F_TR   = 7'h08;
    localparam logic [6:0] F_SYS  = 7'h10;
    localparam logic [6:0] F_RI   = 7'h20;
    localparam logic [6:0] F_IFL  = 7'h40;

    assign ints = {int_ext, int_tr, int_ovf, int_ri, int_sys, int_addrs, int_addrl};

    exception_unit dut (
        .clk          (clk),
        .reset        (reset),
        .if_addrl     (if_addrl),
        .id_ri        (id_ri),
        .id_sys       (id_sys),
        .id_tr        (id_tr),
        .ex_ovf       (ex_ovf),
        .mem_addrs    (mem_addrs),
        .mem_addrl    (mem_addrl),
        .if_pc        (if_pc),
        .id_pc        (id_pc),
        .ex_pc        (ex_pc),
        .mem_pc       (mem_pc),
        .if_badaddr   (if_badaddr),
        .mem_badaddr  (mem_badaddr),
        .irq          (irq),
        .exc_level    (exc_level),
        .int_ext      (int_ext),
        .int_tr       (int_tr),
        .int_ovf      (int_ovf),
        .int_ri       (int_ri),
        .int_sys      (int_sys),
        .int_addrs    (int_addrs),
        .int_addrl    (int_addrl),
        .epc_out      (epc_out),
        .badvaddr_out (badvaddr_out),
        .flush        (flush),
        .stall        (stall),
        .exc_count    (exc_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic set_flags(input logic [6:0] f);
        mem_addrl = f[0];
        mem_addrs = f[1];
        ex_ovf    = f[2];
        id_tr     = f[3];
        id_sys    = f[4];
        id_ri     = f[5];
        if_addrl  = f[6];
    endtask

    // From the REPORT cycle, walk through FLUSH and BUSY back to IDLE.
    task automatic to_idle;
        exc_level = 1'b1;
        step;
        step;
        step;
        exc_level = 1'b0;
        step;
    endtask

    // Full exception sequence from IDLE, checking every phase.
    task automatic run_exc(input string name, input logic [6:0] f, input logic [6:0] exp_int,
                           input logic [31:0] exp_epc, input logic [31:0] exp_bad);
        set_flags(f);
        exc_level = 1'b0;
        step;
        set_flags(7'h00);
        exp_count = exp_count + 16'd1;
        checks++;
        if (ints !== exp_int) begin
            failures++;
            $display("FAIL %s_cause got=%b exp=%b", name, ints, exp_int);
        end
        checks++;
        if (epc_out !== exp_epc) begin
            failures++;
            $display("FAIL %s_epc got=%h exp=%h", name, epc_out, exp_epc);
        end
        checks++;
        if (badvaddr_out !== exp_bad) begin
            failures++;
            $display("FAIL %s_badvaddr got=%h exp=%h", name, badvaddr_out, exp_bad);
        end
        checks++;
        if ({stall, flush} !== 2'b10) begin
            failures++;
            $display("FAIL %s_report_stall_flush got=%b exp=10", name, {stall, flush});
        end
        checks++;
        if (exc_count !== exp_count) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", name, exc_count, exp_count);
        end
        exc_level = 1'b1;
        step;
        checks++;
        if ({ints, stall, flush} !== {E_NONE, 2'b11}) begin
            failures++;
            $display("FAIL %s_flush_phase got=%b exp=%b", name, {ints, stall, flush}, {E_NONE, 2'b11});
        end
        checks++;
        if ({epc_out, badvaddr_out} !== {exp_epc, exp_bad}) begin
            failures++;
            $display("FAIL %s_hold got=%h exp=%h", name, {epc_out, badvaddr_out}, {exp_epc, exp_bad});
        end
        step;
        checks++;
        if ({ints, stall, flush} !== {E_NONE, 2'b00}) begin
            failures++;
            $display("FAIL %s_busy_phase got=%b exp=%b", name, {ints, stall, flush}, {E_NONE, 2'b00});
        end
        step;
        exc_level = 1'b0;
        step;
        step;
        checks++;
        if ({ints, flush} !== {E_NONE, 1'b0}) begin
            failures++;
            $display("FAIL %s_idle_quiet got=%b exp=%b", name, {ints, flush}, {E_NONE, 1'b0});
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({ints, flush, stall} !== 9'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {ints, flush, stall});
        end
        checks++;
        if ({epc_out, badvaddr_out, exc_count} !== 80'b0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {epc_out, badvaddr_out, exc_count});
        end
        step;
        reset = 1'b0;
        step;
        checks++;
        if ({ints, flush, stall} !== 9'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=0", {ints, flush, stall});
        end
    endtask

    task automatic test_reset_irq_level;
        irq   = 1'b1;
        reset = 1'b1;
        step;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if ({dut.irq_pending, ints} !== 8'b0) begin
                failures++;
                $display("FAIL irq_high_at_reset got=%b exp=0", {dut.irq_pending, ints});
            end
        end
        irq = 1'b0;
        step;
    endtask

    task automatic test_ovf;
        run_exc("ovf", F_OVF, E_OVF, 32'h0040_0010, 32'h0);
    endtask

    task automatic test_priority;
        run_exc("addrl_over_sys", F_MEML | F_SYS, E_ADDRL, 32'h0040_0020, 32'h1001_0003);
        run_exc("addrs_over_ovf", F_MEMS | F_OVF | F_IFL, E_ADDRS, 32'h0040_0020, 32'h1001_0003);
        run_exc("ri_over_sys", F_RI | F_SYS | F_TR, E_RI, 32'h0040_0028, 32'h0);
        run_exc("sys_over_tr", F_SYS | F_TR, E_SYS, 32'h0040_0028, 32'h0);
        run_exc("tr_over_ifl", F_TR | F_IFL, E_TR, 32'h0040_0028, 32'h0);
        run_exc("if_addrl", F_IFL, E_ADDRL, 32'h0040_0030, 32'h0040_0031);
    endtask

    task automatic test_busy_irq;
        set_flags(F_OVF);
        step;
        set_flags(7'h00);
        exp_count = exp_count + 16'd1;
        exc_level = 1'b1;
        step;
        step;
        irq   = 1'b1;
        id_ri = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if ({ints, flush} !== 8'b0) begin
                failures++;
                $display("FAIL busy_ignore got=%b exp=0", {ints, flush});
            end
        end
        checks++;
        if (dut.irq_pending !== 1'b1) begin
            failures++;
            $display("FAIL busy_irq_pending got=%b exp=1", dut.irq_pending);
        end
        id_ri     = 1'b0;
        exc_level = 1'b0;
        step;
        checks++;
        if (ints !== E_NONE) begin
            failures++;
            $display("FAIL busy_exit_no_pulse got=%b exp=%b", ints, E_NONE);
        end
        step;
        exp_count = exp_count + 16'd1;
        checks++;
        if ({ints, epc_out, badvaddr_out} !== {E_EXT, 32'h0040_0010, 32'h0}) begin
            failures++;
            $display("FAIL ext_report got=%h exp=%h", {ints, epc_out, badvaddr_out}, {E_EXT, 32'h0040_0010, 32'h0});
        end
        checks++;
        if ({dut.irq_pending, exc_count} !== {1'b0, exp_count}) begin
            failures++;
            $display("FAIL ext_pending_clear got=%h exp=%h", {dut.irq_pending, exc_count}, {1'b0, exp_count});
        end
        to_idle;
        irq = 1'b0;
        step;
        checks++;
        if (ints !== E_NONE) begin
            failures++;
            $display("FAIL ext_single_report got=%b exp=%b", ints, E_NONE);
        end
    endtask

    task automatic test_exc_level_hold;
        exc_level = 1'b1;
        id_ri     = 1'b1;
        irq       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if ({ints, flush, exc_count} !== {E_NONE, 1'b0, exp_count}) begin
                failures++;
                $display("FAIL exl_masked got=%h exp=%h", {ints, flush, exc_count}, {E_NONE, 1'b0, exp_count});
            end
        end
        checks++;
        if (dut.irq_pending !== 1'b1) begin
            failures++;
            $display("FAIL exl_pending_kept got=%b exp=1", dut.irq_pending);
        end
        id_ri     = 1'b0;
        id_tr     = 1'b1;
        exc_level = 1'b0;
        step;
        id_tr     = 1'b0;
        exp_count = exp_count + 16'd1;
        checks++;
        if ({ints, epc_out} !== {E_TR, 32'h0040_0028}) begin
            failures++;
            $display("FAIL tr_over_pending got=%h exp=%h", {ints, epc_out}, {E_TR, 32'h0040_0028});
        end
        checks++;
        if (dut.irq_pending !== 1'b1) begin
            failures++;
            $display("FAIL sync_win_pending_kept got=%b exp=1", dut.irq_pending);
        end
        to_idle;
        step;
        exp_count = exp_count + 16'd1;
        checks++;
        if ({ints, epc_out, exc_count} !== {E_EXT, 32'h0040_0010, exp_count}) begin
            failures++;
            $display("FAIL deferred_ext got=%h exp=%h", {ints, epc_out, exc_count}, {E_EXT, 32'h0040_0010, exp_count});
        end
        to_idle;
        irq = 1'b0;
        step;
    endtask

    task automatic test_reset_in_flush;
        irq = 1'b1;
        step;
        set_flags(F_OVF);
        step;
        set_flags(7'h00);
        exc_level = 1'b1;
        step;
        checks++;
        if (flush !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_flush got=%b exp=1", flush);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ints, flush, stall, dut.irq_pending} !== 10'b0) begin
            failures++;
            $display("FAIL async_reset_ctrl got=%b exp=0", {ints, flush, stall, dut.irq_pending});
        end
        checks++;
        if ({epc_out, badvaddr_out, exc_count} !== 80'b0) begin
            failures++;
            $display("FAIL async_reset_data got=%h exp=0", {epc_out, badvaddr_out, exc_count});
        end
        step;
        reset     = 1'b0;
        irq       = 1'b0;
        exc_level = 1'b0;
        exp_count = 16'd0;
        step;
    endtask

    task automatic test_wrap;
        force dut.count_q = 16'hFFFF;
        #1 release dut.count_q;
        #1;
        exp_count = 16'hFFFF;
        checks++;
        if (exc_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preload got=%h exp=ffff", exc_count);
        end
        step;
        run_exc("wrap", F_SYS, E_SYS, 32'h0040_0028, 32'h0);
        checks++;
        if (exc_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_zero got=%h exp=0000", exc_count);
        end
    endtask

    initial begin
        reset       = 1'b1;
        irq         = 1'b0;
        exc_level   = 1'b0;
        set_flags(7'h00);
        if_pc       = 32'h0040_0030;
        id_pc       = 32'h0040_0028;
        ex_pc       = 32'h0040_0010;
        mem_pc      = 32'h0040_0020;
        if_badaddr  = 32'h0040_0031;
        mem_badaddr = 32'h1001_0003;
        exp_count   = 16'd0;

        test_reset;
        test_reset_irq_level;
        test_ovf;
        test_priority;
        test_busy_irq;
        test_exc_level_hold;
        test_reset_in_flush;
        test_wrap;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
